reg_rename_file: RTL and testbench
==================================

// Module: reg_rename_file
// PURPOSE
//  Architectural register file with per-register rename tags; the receiving end of the ROB commit port.
//  The dispatcher reads rs1/rs2 as value-or-ROB-tag, and tags rd with its new ROB id.
//  The ROB retires results into it (rd, V, Q) and flushes all tags on mispredict.
//  Sits between dispatcher and ROB; values survive a flush, tags do not.
// PARAMETERS
//  REG_NUM    32      architectural registers (x0..x31)
//  REG_W      5       register index width
//  DATA_W     32      register data width
//  ROB_ID_W   5       tag width; tags 0..15 are ROB entries
//  NON_DEP    5'd16   tag value meaning "no pending producer"
// PORTS
//  clk                  in   1         clock, rising edge
//  rst                  in   1         asynchronous, active-high reset
//  rdy                  in   1         global ready; low = hold all state (except flush, below)
//  enable_from_rob      in   1         commit write valid
//  rd_from_rob          in   REG_W     committed destination register
//  V_from_rob           in   DATA_W    committed value
//  Q_from_rob           in   ROB_ID_W  ROB id of the committing entry
//  mispredict           in   1         flush: clear every rename tag
//  rename_en_from_dsp   in   1         tag rd with a new ROB id
//  rename_rd_from_dsp   in   REG_W     register being renamed
//  rename_id_from_dsp   in   ROB_ID_W  ROB id assigned to it
//  rs1_from_dsp         in   REG_W     source 1 index
//  rs2_from_dsp         in   REG_W     source 2 index
//  Vj_to_dsp, Vk_to_dsp out  DATA_W    source values (combinational)
//  Qj_to_dsp, Qk_to_dsp out  ROB_ID_W  source tags; NON_DEP = value valid (combinational)
// BEHAVIOUR
//  - Storage: val[REG_NUM], tag[REG_NUM]. Reset (async): every val = 0, every tag = NON_DEP.
//  - x0: reads always return V = 0, Q = NON_DEP. Commits and renames to x0 are ignored.
//  - Commit at posedge (rdy=1, enable_from_rob, rd != 0):
//    - val[rd] <= V_from_rob.
//    - tag[rd] <= NON_DEP only if tag[rd] == Q_from_rob; a newer producer's tag is kept.
//  - Rename at posedge (rdy=1, rename_en, rd != 0, mispredict=0): tag[rd] <= rename_id.
//  - Same cycle, same rd, commit + rename: val is written, and tag = rename_id (rename wins).
//  - Flush (mispredict=1), applied at the posedge regardless of rdy:
//    - Every tag <= NON_DEP, and any rename that cycle is dropped.
//    - A commit presented the same cycle still writes val (JAL/JALR link retires with the flush).
//  - rdy=0 with mispredict=0: no state change; read ports stay live.
//  - Read ports, pure combinational, for each source s:
//    - s == 0                                            -> (0, NON_DEP)
//    - tag[s] == NON_DEP                                 -> (val[s], NON_DEP)
//    - enable_from_rob, rd_from_rob == s, Q_from_rob == tag[s] -> (V_from_rob, NON_DEP)  [bypass]
//    - otherwise                                         -> (val[s], tag[s])
//  - A same-cycle rename never affects the read ports: the instruction's sources see pre-rename tags.
//  - The dispatcher resolves ready values through the ROB using the returned tag; this block holds no ROB state.
//  - No other latency: every update is visible on the read ports the cycle after the edge.
// TESTING
//  - Reset; read x5 -> V=0, Q=16. Commit x5=0xDEADBEEF, Q=3 while tag[x5]=16 -> next cycle V=0xDEADBEEF, Q=16.
//  - Rename x7->id 4; later commit x7 V=0x11, Q=4 -> tag cleared, V=0x11.
//    Rename x7->id 4 then ->id 9; commit Q=4 -> V updated, Q stays 9.
//  - Same cycle: rename x8->id 2 and commit x8 V=0x55, Q=1 -> V=0x55, Q=2.
//    Same cycle: rs1=x8 reads the pre-edge tag, not 2.
//  - Bypass: tag[x9]=6; in the commit cycle (x9, V=0x77, Q=6), rs2=x9 -> Vk=0x77, Qk=16 combinationally.
//  - Flush: tags x1..x31 = various ids, mispredict=1 with commit x1 V=0x80 Q=tag[x1], plus rename x2->5
//    -> all tags 16, x1=0x80, x2 not renamed. Repeat with rdy=0: identical result.
//  - x0 abuse: commit x0 V=0xFFFF and rename x0->3 -> x0 still reads (0, 16).
//    rdy=0 with commit x4 -> x4 unchanged. Assert rst mid-sequence -> all (0, 16) immediately.

Source files
------------

// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags. The dispatcher reads sources
// as value-or-tag and renames destinations. The ROB commits results here and
// clears every tag on a mispredict flush. Values survive a flush; tags do not.

// One source read port. A source resolves to (value, NON_DEP) when it has no
// pending producer, or when its producer is committing this very cycle.
module reg_rename_rd_port #(
  parameter int                REG_W    = 5,
  parameter int                DATA_W   = 32,
  parameter int                ROB_ID_W = 5,
  parameter logic [ROB_ID_W-1:0] NON_DEP = 5'd16
) (
  input  logic [REG_W-1:0]    rs,
  input  logic [DATA_W-1:0]   val_s,
  input  logic [ROB_ID_W-1:0] tag_s,
  input  logic                cm_en,
  input  logic [REG_W-1:0]    cm_rd,
  input  logic [DATA_W-1:0]   cm_v,
  input  logic [ROB_ID_W-1:0] cm_q,
  output logic [DATA_W-1:0]   v,
  output logic [ROB_ID_W-1:0] q
);

  // Priority: x0, no pending producer, commit bypass, pending tag
  always_comb begin
    v = val_s;
    q = tag_s;
    if (rs == '0) begin
      v = '0;
      q = NON_DEP;
    end else if (tag_s == NON_DEP) begin
      q = NON_DEP;
    end else if (cm_en && cm_rd == rs && cm_q == tag_s) begin
      v = cm_v;
      q = NON_DEP;
    end
  end

endmodule

module reg_rename_file #(
  parameter int                  REG_NUM  = 32,
  parameter int                  REG_W    = 5,
  parameter int                  DATA_W   = 32,
  parameter int                  ROB_ID_W = 5,
  parameter logic [ROB_ID_W-1:0] NON_DEP  = 5'd16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                enable_from_rob,
  input  logic [REG_W-1:0]    rd_from_rob,
  input  logic [DATA_W-1:0]   V_from_rob,
  input  logic [ROB_ID_W-1:0] Q_from_rob,
  input  logic                mispredict,
  input  logic                rename_en_from_dsp,
  input  logic [REG_W-1:0]    rename_rd_from_dsp,
  input  logic [ROB_ID_W-1:0] rename_id_from_dsp,
  input  logic [REG_W-1:0]    rs1_from_dsp,
  input  logic [REG_W-1:0]    rs2_from_dsp,
  output logic [DATA_W-1:0]   Vj_to_dsp,
  output logic [DATA_W-1:0]   Vk_to_dsp,
  output logic [ROB_ID_W-1:0] Qj_to_dsp,
  output logic [ROB_ID_W-1:0] Qk_to_dsp
);

  localparam int NUM_RD = 2;

  logic [REG_NUM-1:0][DATA_W-1:0]   val;
  logic [REG_NUM-1:0][ROB_ID_W-1:0] tag;

  logic commit_ok;
  logic rename_ok;

  // x0 is hardwired: never written, never tagged
  assign commit_ok = enable_from_rob && (rd_from_rob != '0);
  assign rename_ok = rename_en_from_dsp && (rename_rd_from_dsp != '0);

  // Storage update. Flush ignores rdy and drops any rename, but a commit in
  // the flush cycle (link register of a JAL/JALR) still lands its value.
  // Rename is written last so it overrides a same-register commit tag clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val[i] <= '0;
        tag[i] <= NON_DEP;
      end
    end else if (mispredict) begin
      for (int i = 0; i < REG_NUM; i++) tag[i] <= NON_DEP;
      if (commit_ok) val[rd_from_rob] <= V_from_rob;
    end else if (rdy) begin
      if (commit_ok) begin
        val[rd_from_rob] <= V_from_rob;
        // only clear when the committing entry is still the newest producer
        if (tag[rd_from_rob] == Q_from_rob) tag[rd_from_rob] <= NON_DEP;
      end
      if (rename_ok) tag[rename_rd_from_dsp] <= rename_id_from_dsp;
    end
  end

  logic [NUM_RD-1:0][REG_W-1:0]    rs;
  logic [NUM_RD-1:0][DATA_W-1:0]   rv;
  logic [NUM_RD-1:0][ROB_ID_W-1:0] rq;

  assign rs = {rs2_from_dsp, rs1_from_dsp};

  // Read ports see pre-edge state; a same-cycle rename never reaches them
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_rename_rd_port #(
      .REG_W(REG_W), .DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W), .NON_DEP(NON_DEP)
    ) u_port (
      .rs    (rs[p]),
      .val_s (val[rs[p]]),
      .tag_s (tag[rs[p]]),
      .cm_en (enable_from_rob),
      .cm_rd (rd_from_rob),
      .cm_v  (V_from_rob),
      .cm_q  (Q_from_rob),
      .v     (rv[p]),
      .q     (rq[p])
    );
  end

  assign Vj_to_dsp = rv[0];
  assign Qj_to_dsp = rq[0];
  assign Vk_to_dsp = rv[1];
  assign Qk_to_dsp = rq[1];

endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: the stimulus process computes the
// expected read-port response from an array-based reference model and queues
// it; a monitor pops and compares on every falling edge.
module tb_reg_rename_file;

  localparam logic [4:0] ND = 5'd16;

  logic        clk = 1'b0;
  logic        rst, rdy, en, mis, ren;
  logic [4:0]  rd, q_rob, rrd, rid, rs1, rs2;
  logic [31:0] v_rob;
  logic [31:0] vj, vk;
  logic [4:0]  qj, qk;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enable_from_rob(en), .rd_from_rob(rd), .V_from_rob(v_rob), .Q_from_rob(q_rob),
    .mispredict(mis),
    .rename_en_from_dsp(ren), .rename_rd_from_dsp(rrd), .rename_id_from_dsp(rid),
    .rs1_from_dsp(rs1), .rs2_from_dsp(rs2),
    .Vj_to_dsp(vj), .Vk_to_dsp(vk), .Qj_to_dsp(qj), .Qk_to_dsp(qk)
  );

  typedef struct {
    logic        rst, rdy, en, mis, ren;
    logic [4:0]  rd, q, rrd, rid, rs1, rs2;
    logic [31:0] v;
  } stim_t;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] vj, vk;
    logic [4:0]  qj, qk;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mval[32];
  logic [4:0]  mtag[32];
  int          checks = 0;
  int          errors = 0;

  function automatic stim_t idle(input logic [4:0] a, input logic [4:0] b);
    stim_t s;
    s = '{default: '0};
    s.rdy = 1'b1;
    s.rs1 = a;
    s.rs2 = b;
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mval[i] = '0;
      mtag[i] = ND;
    end
  endfunction

  // What the dispatcher should see for source s given the model state and
  // the commit being presented right now.
  function automatic void model_read(input stim_t s, input logic [4:0] r,
                                     output logic [31:0] v, output logic [4:0] q);
    if (r == 0) begin
      v = '0; q = ND;
    end else if (mtag[r] == ND) begin
      v = mval[r]; q = ND;
    end else if (s.en && s.rd == r && s.q == mtag[r]) begin
      v = s.v; q = ND;
    end else begin
      v = mval[r]; q = mtag[r];
    end
  endfunction

  // State after the clock edge
  function automatic void model_step(input stim_t s);
    logic [4:0] old_tag;
    if (s.mis) begin
      if (s.en && s.rd != 0) mval[s.rd] = s.v;
      for (int i = 0; i < 32; i++) mtag[i] = ND;
    end else if (s.rdy) begin
      if (s.en && s.rd != 0) begin
        old_tag = mtag[s.rd];
        mval[s.rd] = s.v;
        if (old_tag == s.q) mtag[s.rd] = ND;
      end
      if (s.ren && s.rrd != 0) mtag[s.rrd] = s.rid;
    end
  endfunction

  // Present one cycle of stimulus (called just after a rising edge)
  task automatic issue(input stim_t s);
    exp_t e;
    rst = s.rst; rdy = s.rdy; en = s.en; rd = s.rd; v_rob = s.v; q_rob = s.q;
    mis = s.mis; ren = s.ren; rrd = s.rrd; rid = s.rid; rs1 = s.rs1; rs2 = s.rs2;
    if (s.rst) model_reset();
    e.rs1 = s.rs1;
    e.rs2 = s.rs2;
    model_read(s, s.rs1, e.vj, e.qj);
    model_read(s, s.rs2, e.vk, e.qk);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!s.rst) model_step(s);
  endtask

  // Monitor: the read ports are valid every cycle; compare mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (vj !== e.vj || qj !== e.qj) begin
        errors++;
        $display("FAIL rs1 x%0d: got V=%h Q=%0d, expected V=%h Q=%0d", e.rs1, vj, qj, e.vj, e.qj);
      end
      checks++;
      if (vk !== e.vk || qk !== e.qk) begin
        errors++;
        $display("FAIL rs2 x%0d: got V=%h Q=%0d, expected V=%h Q=%0d", e.rs2, vk, qk, e.vk, e.qk);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

  task automatic flush_test(input logic rdy_val);
    stim_t s;
    for (int i = 1; i < 32; i++) begin
      s = idle(5'(i), 5'(i - 1));
      s.ren = 1'b1; s.rrd = 5'(i); s.rid = 5'(i % 16);
      issue(s);
    end
    s = idle(5'd1, 5'd2);
    s.rdy = rdy_val; s.mis = 1'b1;
    s.en = 1'b1; s.rd = 5'd1; s.v = 32'h80; s.q = mtag[1];
    s.ren = 1'b1; s.rrd = 5'd2; s.rid = 5'd5;
    issue(s);
    for (int i = 0; i < 16; i++) issue(idle(5'(2 * i), 5'(2 * i + 1)));
  endtask

  initial begin
    stim_t s;
    model_reset();
    rst = 1'b1; rdy = 1'b1; en = 0; rd = 0; v_rob = 0; q_rob = 0;
    mis = 0; ren = 0; rrd = 0; rid = 0; rs1 = 0; rs2 = 0;
    @(posedge clk);
    #1;

    // reset state
    s = idle(5'd5, 5'd0); s.rst = 1'b1; issue(s);
    issue(idle(5'd5, 5'd31));

    // commit to an untagged register
    s = idle(5'd5, 5'd5); s.en = 1; s.rd = 5; s.v = 32'hDEADBEEF; s.q = 3; issue(s);
    issue(idle(5'd5, 5'd0));

    // rename then commit by the same producer
    s = idle(5'd7, 5'd0); s.ren = 1; s.rrd = 7; s.rid = 4; issue(s);
    s = idle(5'd0, 5'd7); s.en = 1; s.rd = 7; s.v = 32'h11; s.q = 4; issue(s);
    issue(idle(5'd7, 5'd0));

    // newer producer survives an older commit
    s = idle(5'd7, 5'd0); s.ren = 1; s.rrd = 7; s.rid = 4; issue(s);
    s = idle(5'd7, 5'd0); s.ren = 1; s.rrd = 7; s.rid = 9; issue(s);
    s = idle(5'd7, 5'd0); s.en = 1; s.rd = 7; s.v = 32'h22; s.q = 4; issue(s);
    issue(idle(5'd7, 5'd0));

    // same-cycle rename and commit on one register; sources see pre-edge tag
    s = idle(5'd8, 5'd8); s.ren = 1; s.rrd = 8; s.rid = 2;
    s.en = 1; s.rd = 8; s.v = 32'h55; s.q = 1; issue(s);
    issue(idle(5'd8, 5'd0));

    // commit bypass on the read port
    s = idle(5'd0, 5'd9); s.ren = 1; s.rrd = 9; s.rid = 6; issue(s);
    s = idle(5'd0, 5'd9); s.en = 1; s.rd = 9; s.v = 32'h77; s.q = 6; issue(s);
    issue(idle(5'd9, 5'd9));

    // flush with and without rdy
    flush_test(1'b1);
    flush_test(1'b0);

    // x0 cannot be written or renamed
    s = idle(5'd0, 5'd0); s.en = 1; s.rd = 0; s.v = 32'hFFFF; s.q = 0;
    s.ren = 1; s.rrd = 0; s.rid = 3; issue(s);
    issue(idle(5'd0, 5'd0));

    // rdy low holds state
    s = idle(5'd4, 5'd0); s.rdy = 0; s.en = 1; s.rd = 4; s.v = 32'h1234; s.q = 0;
    s.ren = 1; s.rrd = 4; s.rid = 7; issue(s);
    issue(idle(5'd4, 5'd0));

    // mid-sequence reset
    s = idle(5'd5, 5'd7); s.ren = 1; s.rrd = 5; s.rid = 11; issue(s);
    s = idle(5'd5, 5'd7); s.rst = 1; issue(s);
    issue(idle(5'd5, 5'd7));

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      s = idle(5'($urandom_range(31)), 5'($urandom_range(31)));
      s.rdy = ($urandom_range(7) != 0);
      s.en  = $urandom_range(1);
      s.rd  = 5'($urandom_range(31));
      s.v   = $urandom;
      s.q   = $urandom_range(1) ? mtag[s.rd] : 5'($urandom_range(16));
      s.mis = ($urandom_range(19) == 0);
      s.ren = $urandom_range(1);
      s.rrd = $urandom_range(3) == 0 ? s.rd : 5'($urandom_range(31));
      s.rid = 5'($urandom_range(15));
      if ($urandom_range(2) == 0) s.rs1 = s.rd;
      if ($urandom_range(2) == 0) s.rs2 = s.rd;
      s.rst = ($urandom_range(299) == 0);
      issue(s);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
